// File: rtl/store_write_buffer_pkg.sv
// Shared types and defaults for the posted-store write buffer.
// Optional forwarding is controlled by STORE_WBUF_FWD_EN (see top level).
package store_write_buffer_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        GAP   = 2'b10
    } wbuf_state_t;

endpackage

// File: rtl/store_write_buffer_fifo.sv
// Register FIFO for buffered stores; exposes entries ordered oldest-first.
// Used by store_write_buffer (STORE_WBUF_FWD_EN selects forwarding there).
module wbuf_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [ADDR_W-1:0]             head_addr,
    output logic [DATA_W-1:0]             head_data,
    output logic [DEPTH-1:0]              age_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  age_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]  age_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; validity is derived from the count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_comb begin
        age_valid = '0;
        age_addr  = '0;
        age_data  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            age_valid[k] = (CNT_W'(k) < cnt);
            age_addr[k]  = addr_mem[rd_ptr + PTR_W'(k)];
            age_data[k]  = data_mem[rd_ptr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer draining CPU stores as distinct mem_wen pulses.
// Define STORE_WBUF_FWD_EN to forward buffered data to hazarding loads.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ren,
    output logic              cpu_stall,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              empty
);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             age_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] age_addr;
    logic [DEPTH-1:0][DATA_W-1:0] age_data;

    wbuf_state_t state;
    wbuf_state_t state_nxt;
    logic        load;
    logic        pop;

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_wen),
        .push_addr (cpu_addr),
        .push_data (cpu_wdata),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .age_valid (age_valid),
        .age_addr  (age_addr),
        .age_data  (age_data)
    );

    // GAP behaves like IDLE for the next decision; its only purpose is
    // to force one low cycle on mem_wen between drained stores.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        unique case (state)
            IDLE, GAP: begin
                if (!fifo_empty) begin
                    state_nxt = WRITE;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    pop       = 1'b1;
                    state_nxt = GAP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state   <= state_nxt;
            mem_wen <= (state_nxt == WRITE);
            if (load) begin
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
            end
        end
    end

    assign empty = fifo_empty && (state == IDLE);

    logic              match;
    logic [DATA_W-1:0] match_data;
    logic              hazard;
    logic              full_stall;

    // Scan oldest to youngest so the youngest matching store wins.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        if ((state == WRITE) && (mem_addr == cpu_addr)) begin
            match      = 1'b1;
            match_data = mem_wdata;
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (age_valid[k] && (age_addr[k] == cpu_addr)) begin
                match      = 1'b1;
                match_data = age_data[k];
            end
        end
    end

    assign hazard     = cpu_ren && match;
    assign full_stall = cpu_wen && fifo_full;

`ifdef STORE_WBUF_FWD_EN
    assign fwd_hit   = hazard;
    assign fwd_data  = hazard ? match_data : '0;
    assign cpu_stall = full_stall;
`else
    logic unused_fwd;
    assign unused_fwd = ^match_data;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign cpu_stall  = full_stall || hazard;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer with a queue-based model.
// Honours STORE_WBUF_FWD_EN to select the expected load-hazard behaviour.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 30;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ren;
    logic          cpu_stall;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          empty;

    store_write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ren   (cpu_ren),
        .cpu_stall (cpu_stall),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    st_t q[$];
    st_t wlog[$];
    bit  pushed;
    bit  accepted;

    task automatic drive(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic r,
                         input logic rdy);
        cpu_wen   = w;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_ren   = r;
        mem_ready = rdy;
    endtask

    // Model: pending stores in order; the head leaves on each accepted write.
    task automatic tick();
        bit full_m;
        #1;
        accepted = mem_wen && mem_ready;
        pushed   = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            full_m = (q.size() == DEPTH);
            if (accepted) begin
                wlog.push_back('{mem_addr, mem_wdata});
                if (q.size() > 0) void'(q.pop_front());
            end
            if (cpu_wen && !full_m) begin
                q.push_back('{cpu_addr, cpu_wdata});
                pushed = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, '0, '0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_wen !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_wen got %b want 0", mem_wen);
        end
        n_checks++;
        if (mem_addr !== '0) begin
            n_fail++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr);
        end
        n_checks++;
        if (mem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata);
        end
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_empty got %b want 1", empty);
        end
        n_checks++;
        if ({cpu_stall, fwd_hit, fwd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_comb got stall=%b hit=%b data=%0h want 0",
                     cpu_stall, fwd_hit, fwd_data);
        end
        wlog.delete();
    endtask

    task automatic test_single_store();
        int first = -1;
        int highs = 0;
        wlog.delete();
        drive(1, 30'hFF, 32'h68010000, 0, 1);
        #1;
        n_checks++;
        if (cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL single_stall got %b want 0", cpu_stall);
        end
        tick();
        for (int c = 1; c <= 7; c++) begin
            drive(0, '0, '0, 0, 1);
            #1;
            if (mem_wen) begin
                highs++;
                if (first < 0) first = c;
            end
            tick();
        end
        n_checks++;
        if (first != 2) begin
            n_fail++; $display("FAIL single_latency got %0d want 2", first);
        end
        n_checks++;
        if (highs != 1) begin
            n_fail++; $display("FAIL single_pulse_len got %0d want 1", highs);
        end
        n_checks++;
        if (wlog.size() != 1 || wlog[0].a !== 30'hFF ||
            wlog[0].d !== 32'h68010000) begin
            n_fail++;
            $display("FAIL single_write got n=%0d a=%0h d=%0h want n=1 a=ff d=68010000",
                     wlog.size(), wlog[0].a, wlog[0].d);
        end
        #1;
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL single_empty got %b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [4];
        int  stalls = 0;
        int  adj    = 0;
        bit  prev   = 0;
        exp_d = '{32'd0, 32'd1, 32'd1, 32'd2};
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 30'hFF, exp_d[i], 0, 1);
            #1;
            if (cpu_stall) stalls++;
            if (prev && mem_wen) adj++;
            prev = mem_wen;
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            drive(0, '0, '0, 0, 1);
            #1;
            if (prev && mem_wen) adj++;
            prev = mem_wen;
            tick();
        end
        n_checks++;
        if (stalls != 0) begin
            n_fail++; $display("FAIL b2b_stall got %0d stall cycles want 0", stalls);
        end
        n_checks++;
        if (adj != 0) begin
            n_fail++; $display("FAIL b2b_gap got %0d adjacent pulses want 0", adj);
        end
        n_checks++;
        if (wlog.size() != 4) begin
            n_fail++; $display("FAIL b2b_count got %0d want 4", wlog.size());
        end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].a !== 30'hFF || wlog[i].d !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_order[%0d] got %0h/%0h want ff/%0h",
                         i, wlog[i].a, wlog[i].d, exp_d[i]);
            end
        end
    endtask

    task automatic test_full_stall();
        st_t exp [6];
        int  early = 0;
        int  miss = 0;
        int  unstable = 0;
        int  idx;
        wlog.delete();
        for (int i = 0; i < 6; i++) exp[i] = '{AW'(32'h100 + i), DW'($urandom)};
        for (int i = 0; i < 4; i++) begin
            drive(1, exp[i].a, exp[i].d, 0, 0);
            #1;
            if (cpu_stall) early++;
            tick();
        end
        drive(1, exp[4].a, exp[4].d, 0, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (!cpu_stall) miss++;
            if (!mem_wen || mem_addr !== exp[0].a || mem_wdata !== exp[0].d)
                unstable++;
            tick();
        end
        n_checks++;
        if (early != 0) begin
            n_fail++; $display("FAIL full_early_stall got %0d want 0", early);
        end
        n_checks++;
        if (miss != 0) begin
            n_fail++; $display("FAIL full_stall got %0d unstalled cycles want 0", miss);
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++; $display("FAIL full_hold got %0d unstable cycles want 0", unstable);
        end
        idx = 4;
        for (int c = 0; c < 80 && wlog.size() < 6; c++) begin
            if (idx < 6) drive(1, exp[idx].a, exp[idx].d, 0, 1);
            else         drive(0, '0, '0, 0, 1);
            tick();
            if (pushed) idx++;
        end
        drive(0, '0, '0, 0, 1);
        n_checks++;
        if (wlog.size() != 6) begin
            n_fail++; $display("FAIL full_drain_count got %0d want 6", wlog.size());
        end
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].a !== exp[i].a || wlog[i].d !== exp[i].d) begin
                n_fail++;
                $display("FAIL full_order[%0d] got %0h/%0h want %0h/%0h",
                         i, wlog[i].a, wlog[i].d, exp[i].a, exp[i].d);
            end
        end
    endtask

    task automatic test_load_hazard();
        int hz = 0;
        wlog.delete();
        drive(1, 30'h10, 32'h5, 0, 1);
        tick();
        drive(0, 30'h10, '0, 1, 1);
        #1;
`ifdef STORE_WBUF_FWD_EN
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h5 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_first got hit=%b data=%0h stall=%b want 1/5/0",
                     fwd_hit, fwd_data, cpu_stall);
        end
`else
        n_checks++;
        if (cpu_stall !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== '0) begin
            n_fail++;
            $display("FAIL ld_stall_first got stall=%b hit=%b data=%0h want 1/0/0",
                     cpu_stall, fwd_hit, fwd_data);
        end
`endif
        for (int c = 0; c < 10; c++) begin
            drive(0, 30'h10, '0, 1, 1);
            #1;
`ifdef STORE_WBUF_FWD_EN
            if (fwd_hit) hz++;
`else
            if (cpu_stall) hz++;
`endif
            tick();
        end
        n_checks++;
        if (hz != 2) begin
            n_fail++; $display("FAIL ld_hazard_cycles got %0d want 2", hz);
        end
        n_checks++;
        if (wlog.size() != 1 || wlog[0].d !== 32'h5) begin
            n_fail++;
            $display("FAIL ld_write got n=%0d d=%0h want 1/5", wlog.size(), wlog[0].d);
        end
        drive(1, 30'h20, 32'hA, 0, 0); tick();
        drive(1, 30'h20, 32'hB, 0, 0); tick();
        drive(1, 30'h21, 32'hC, 0, 0); tick();
        drive(0, 30'h20, '0, 1, 0);
        #1;
`ifdef STORE_WBUF_FWD_EN
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'hB || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_youngest got hit=%b data=%0h stall=%b want 1/b/0",
                     fwd_hit, fwd_data, cpu_stall);
        end
`else
        n_checks++;
        if (cpu_stall !== 1'b1 || fwd_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_multi_stall got stall=%b hit=%b want 1/0",
                     cpu_stall, fwd_hit);
        end
`endif
        drive(0, 30'h22, '0, 1, 0);
        #1;
        n_checks++;
        if (cpu_stall !== 1'b0 || fwd_hit !== 1'b0 || fwd_data !== '0) begin
            n_fail++;
            $display("FAIL ld_nomatch got stall=%b hit=%b data=%0h want 0/0/0",
                     cpu_stall, fwd_hit, fwd_data);
        end
        for (int c = 0; c < 30 && !(q.size() == 0 && empty); c++) begin
            drive(0, '0, '0, 0, 1);
            tick();
        end
    endtask

    task automatic test_reset_in_write();
        int highs = 0;
        wlog.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(32'h30 + i), DW'(32'hC0 + i), 0, 0);
            tick();
        end
        drive(0, '0, '0, 0, 0);
        #1;
        n_checks++;
        if (mem_wen !== 1'b1) begin
            n_fail++; $display("FAIL rstw_in_write got %b want 1", mem_wen);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, '0, '0, 0, 1);
        #1;
        n_checks++;
        if (mem_wen !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_after got wen=%b empty=%b want 0/1", mem_wen, empty);
        end
        for (int c = 0; c < 10; c++) begin
            drive(0, '0, '0, 0, 1);
            #1;
            if (mem_wen) highs++;
            tick();
        end
        n_checks++;
        if (highs != 0 || wlog.size() != 0) begin
            n_fail++;
            $display("FAIL rstw_no_writes got %0d pulses %0d writes want 0/0",
                     highs, wlog.size());
        end
    endtask

    task automatic test_push_pop_same();
        st_t exp [6];
        int  bad_stall = 0;
        int  idx;
        wlog.delete();
        for (int i = 0; i < 6; i++) exp[i] = '{AW'(32'h200 + i), DW'($urandom)};
        drive(1, exp[0].a, exp[0].d, 0, 0); tick();
        drive(1, exp[1].a, exp[1].d, 0, 0); tick();
        drive(1, exp[2].a, exp[2].d, 0, 1);
        #1;
        n_checks++;
        if (mem_wen !== 1'b1 || mem_addr !== exp[0].a) begin
            n_fail++;
            $display("FAIL pp_head got wen=%b a=%0h want 1/%0h",
                     mem_wen, mem_addr, exp[0].a);
        end
        if (cpu_stall) bad_stall++;
        tick();
        for (int i = 3; i < 5; i++) begin
            drive(1, exp[i].a, exp[i].d, 0, 0);
            #1;
            if (cpu_stall) bad_stall++;
            tick();
        end
        n_checks++;
        if (bad_stall != 0) begin
            n_fail++; $display("FAIL pp_early_stall got %0d want 0", bad_stall);
        end
        drive(1, exp[5].a, exp[5].d, 0, 0);
        #1;
        n_checks++;
        if (cpu_stall !== 1'b1) begin
            n_fail++; $display("FAIL pp_full_at_4 got %b want 1", cpu_stall);
        end
        idx = 5;
        for (int c = 0; c < 80 && wlog.size() < 6; c++) begin
            if (idx < 6) drive(1, exp[idx].a, exp[idx].d, 0, 1);
            else         drive(0, '0, '0, 0, 1);
            tick();
            if (pushed) idx++;
        end
        drive(0, '0, '0, 0, 1);
        n_checks++;
        if (wlog.size() != 6) begin
            n_fail++; $display("FAIL pp_drain_count got %0d want 6", wlog.size());
        end
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].a !== exp[i].a || wlog[i].d !== exp[i].d) begin
                n_fail++;
                $display("FAIL pp_order[%0d] got %0h/%0h want %0h/%0h",
                         i, wlog[i].a, wlog[i].d, exp[i].a, exp[i].d);
            end
        end
    endtask

    task automatic test_random();
        logic          w = 0;
        logic [AW-1:0] a = '0;
        logic [DW-1:0] d = '0;
        logic          r;
        logic          rdy;
        bit            hold = 0;
        bit            prev_acc = 0;
        bit            m;
        logic [DW-1:0] md;
        bit            e_stall;
        bit            e_hit;
        logic [DW-1:0] e_data;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                w = 1'($urandom_range(0, 1));
                a = AW'($urandom_range(0, 7));
                d = DW'($urandom);
            end
            r   = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            drive(w, a, d, r, rdy);
            #1;
            m  = 0;
            md = '0;
            foreach (q[i]) if (q[i].a == a) begin m = 1; md = q[i].d; end
`ifdef STORE_WBUF_FWD_EN
            e_stall = w && (q.size() == DEPTH);
            e_hit   = r && m;
            e_data  = e_hit ? md : '0;
`else
            e_stall = (w && (q.size() == DEPTH)) || (r && m);
            e_hit   = 0;
            e_data  = '0;
`endif
            n_checks++;
            if (cpu_stall !== e_stall) begin
                n_fail++;
                $display("FAIL rnd_stall c=%0d got %b want %b", c, cpu_stall, e_stall);
            end
            n_checks++;
            if (fwd_hit !== e_hit || fwd_data !== e_data) begin
                n_fail++;
                $display("FAIL rnd_fwd c=%0d got %b/%0h want %b/%0h",
                         c, fwd_hit, fwd_data, e_hit, e_data);
            end
            if (mem_wen) begin
                n_checks++;
                if (q.size() == 0 || mem_addr !== q[0].a || mem_wdata !== q[0].d) begin
                    n_fail++;
                    $display("FAIL rnd_head c=%0d got %0h/%0h want %0h/%0h (n=%0d)",
                             c, mem_addr, mem_wdata, q[0].a, q[0].d, q.size());
                end
            end
            n_checks++;
            if (prev_acc && mem_wen) begin
                n_fail++; $display("FAIL rnd_gap c=%0d got wen=1 want 0", c);
            end
            n_checks++;
            if (empty && q.size() != 0) begin
                n_fail++;
                $display("FAIL rnd_empty c=%0d got 1 want 0 (n=%0d)", c, q.size());
            end
            prev_acc = mem_wen && rdy;
            tick();
            hold = w && !pushed;
        end
        for (int c = 0; c < 60; c++) begin
            drive(0, '0, '0, 0, 1);
            #1;
            if (q.size() == 0 && empty) break;
            tick();
        end
        n_checks++;
        if (q.size() != 0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_drain got pending=%0d empty=%b want 0/1", q.size(), empty);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        test_reset();
        test_single_store();
        test_back_to_back();
        test_full_stall();
        test_load_hazard();
        test_reset_in_write();
        test_push_pop_same();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
